trace_event_buffer: RTL and testbench
=====================================

// Module: trace_event_buffer
// PURPOSE
//  Synthesizable, parametrised debug monitor that replaces simulation-only $display tracing.
//  Watches NUM_CH status channels (FSM state, SPI byte, buffer addr, BNN result, ...) for changes.
//  Each cycle with a change writes one timestamped entry into an on-chip FIFO.
//  The FIFO is drained through a valid/ready port, e.g. by the SPI response path.
// PARAMETERS
//  NUM_CH    4   number of monitored channels
//  CH_W      10  width of each channel (narrower signals zero-extended by the instantiator)
//  DEPTH     16  FIFO entries; power of two, >=2
//  TS_W      16  timestamp width; free-running, wraps
//  DROP_W    8   drop counter width; saturating
//  OVERWRITE 0   0: stop-on-full (new events dropped); 1: overwrite oldest entry
// PORTS
//  clk            in   1               system clock
//  rst            in   1               synchronous, active-high reset
//  trace_enable   in   1               1 = monitor running
//  clear          in   1               synchronous flush of FIFO, drop_count and lost flag
//  ch_mask        in   NUM_CH          per-channel change-detect enable
//  ch_data        in   NUM_CH*CH_W     channel i = ch_data[i*CH_W +: CH_W]
//  rd_valid       out  1               FIFO non-empty
//  rd_ready       in   1               consumer accepts rd_data
//  rd_data        out  E               E = 1+TS_W+NUM_CH+NUM_CH*CH_W: {lost,ts,chg_mask,ch_data}
//  fill_level     out  $clog2(DEPTH)+1 current entry count, 0..DEPTH
//  full           out  1               fill_level == DEPTH
//  drop_count     out  DROP_W          events lost (stop mode) or entries overwritten (overwrite mode)
// BEHAVIOUR
//  Reset
//   - FSM = IDLE; ts = 0; prev = 0; pointers = 0; drop_count = 0; lost = 0.
//   - rd_valid = 0; full = 0; fill_level = 0; rd_data = don't-care while rd_valid = 0.
//  Timestamp: ts increments every cycle after reset regardless of state; wraps 2^TS_W-1 -> 0.
//  FSM
//   - IDLE -> ARM when trace_enable = 1.
//   - ARM: load prev <= ch_data, record nothing; -> RUN next cycle.
//   - RUN: prev <= ch_data every cycle.
//   - RUN/ARM -> IDLE when trace_enable = 0. FIFO contents are kept and stay readable.
//  Change detect (RUN only)
//   - chg[i] = ch_mask[i] & (ch_data_i != prev_i).
//   - Event when |chg.
//   - Entry = {lost, ts, chg, ch_data}, all sampled at that same edge.
//   - Entry is readable (rd_valid = 1) the cycle after the edge, i.e. latency 1.
//  FIFO
//   - First-word-fall-through: rd_data = head entry while rd_valid = 1.
//   - Pop on rd_valid & rd_ready; pointers carry one extra wrap bit.
//   - Push and pop in the same cycle are both performed:
//     - level unchanged, including when full;
//     - no drop in either mode;
//     - when empty, only the push occurs.
//   - Full + event + no pop:
//     - OVERWRITE = 0: event discarded, drop_count++, lost <= 1.
//     - OVERWRITE = 1: oldest entry discarded (rd ptr advances), new entry written,
//       drop_count++, lost <= 1; fill_level stays DEPTH.
//   - lost is written into the next accepted entry, then cleared in that cycle.
//   - drop_count saturates at 2^DROP_W-1.
//  clear
//   - Empties the FIFO and zeroes drop_count and lost.
//   - Takes priority over a push/pop in the same cycle (that event is not recorded).
//   - Does not touch the FSM, ts or prev.
//  rst mid-operation: returns to reset values on the next edge; an in-flight push is abandoned.
// TESTING
//  1. Reset, enable, hold ch_data constant 50 cycles
//     -> ARM records nothing; rd_valid stays 0; fill_level = 0.
//  2. RUN: ch0 0->5 at ts = 7, ch_mask = 4'b1111
//     -> next cycle rd_valid = 1, rd_data = {0, 16'd7, 4'b0001, data};
//     -> ch0 0->5 with ch_mask[0] = 0 records nothing.
//  3. OVERWRITE = 0, DEPTH = 16: 18 events, no reads
//     -> full = 1, drop_count = 2; after 1 pop + 1 event the new entry has lost = 1.
//  4. OVERWRITE = 1: 20 events with ts 100..119, then drain
//     -> first entry ts = 104 with lost = 0; drop_count = 4; entry ts = 119 lost = 1.
//  5. Full FIFO, event + rd_ready in the same cycle
//     -> fill_level stays 16, drop_count unchanged; clear + event in the same cycle -> level = 0.
//  6. TS_W = 4: events at ts 14 and 1 (after wrap) -> stamps 14 and 1;
//     -> drop trace_enable -> entries still drain; re-enable -> ARM, no spurious event.

Source files
------------

// File: rtl/trace_event_buffer.sv
// Debug trace monitor: watches status channels and writes timestamped change
// events into a first-word-fall-through FIFO that is drained over valid/ready.
module trace_event_buffer #(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned CH_W      = 10,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned TS_W      = 16,
   parameter int unsigned DROP_W    = 8,
   parameter int unsigned OVERWRITE = 0
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   trace_enable,
   input  logic                                   clear,
   input  logic [NUM_CH-1:0]                      ch_mask,
   input  logic [NUM_CH*CH_W-1:0]                 ch_data,
   output logic                                   rd_valid,
   input  logic                                   rd_ready,
   output logic [1+TS_W+NUM_CH+NUM_CH*CH_W-1:0]   rd_data,
   output logic [$clog2(DEPTH):0]                 fill_level,
   output logic                                   full,
   output logic [DROP_W-1:0]                      drop_count
);

   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned D_W = NUM_CH * CH_W;
   localparam int unsigned E_W = 1 + TS_W + NUM_CH + D_W;

   typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

   state_t              r_state;
   logic [TS_W-1:0]     r_ts;
   logic [D_W-1:0]      r_prev;
   logic [AW:0]         r_wr;
   logic [AW:0]         r_rd;
   logic [AW:0]         r_count;
   logic                r_valid;
   logic                r_full;
   logic                r_lost;
   logic [DROP_W-1:0]   r_drop;
   logic [E_W-1:0]      r_head;
   logic [E_W-1:0]      r_mem [DEPTH];

   logic [NUM_CH-1:0]   w_chg;
   logic                w_event;
   logic                w_pop;
   logic                w_drop;
   logic                w_push;
   logic                w_adv;
   logic [AW:0]         w_wr_nxt;
   logic [AW:0]         w_rd_nxt;
   logic [AW:0]         w_cnt_nxt;
   logic [E_W-1:0]      w_entry;
   logic [E_W-1:0]      w_head_nxt;

   // Per-channel change detect against the previous cycle's sample
   always_comb begin
      w_chg = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_chg[i] = ch_mask[i] & (ch_data[i*CH_W +: CH_W] != r_prev[i*CH_W +: CH_W]);
      end
   end

   // A full FIFO with no pop either drops the event or evicts the oldest entry
   always_comb begin
      w_event    = (r_state == RUN) & trace_enable & (|w_chg);
      w_pop      = r_valid & rd_ready;
      w_drop     = w_event & r_full & ~w_pop;
      w_push     = w_event & (~w_drop | (OVERWRITE != 0));
      w_adv      = w_pop | (w_drop & (OVERWRITE != 0));
      w_entry    = {r_lost, r_ts, w_chg, ch_data};
      w_wr_nxt   = r_wr + (AW+1)'(w_push);
      w_rd_nxt   = r_rd + (AW+1)'(w_adv);
      w_cnt_nxt  = w_wr_nxt - w_rd_nxt;
      // Head bypass covers a push into an empty FIFO
      w_head_nxt = (w_push && (w_rd_nxt[AW-1:0] == r_wr[AW-1:0])) ? w_entry
                                                                 : r_mem[w_rd_nxt[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (w_push && !clear && !rst) begin
         r_mem[r_wr[AW-1:0]] <= w_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_ts    <= '0;
         r_prev  <= '0;
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         r_valid <= 1'b0;
         r_full  <= 1'b0;
         r_lost  <= 1'b0;
         r_drop  <= '0;
         r_head  <= '0;
      end else begin
         r_ts <= r_ts + TS_W'(1);
         case (r_state)
            IDLE: if (trace_enable) r_state <= ARM;
            ARM: begin
               r_prev  <= ch_data;
               r_state <= trace_enable ? RUN : IDLE;
            end
            RUN: begin
               r_prev <= ch_data;
               if (!trace_enable) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase

         if (clear) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_full  <= 1'b0;
            r_lost  <= 1'b0;
            r_drop  <= '0;
         end else begin
            r_wr    <= w_wr_nxt;
            r_rd    <= w_rd_nxt;
            r_count <= w_cnt_nxt;
            r_valid <= (w_cnt_nxt != '0);
            r_full  <= (w_cnt_nxt == (AW+1)'(DEPTH));
            r_head  <= w_head_nxt;
            if (w_drop) begin
               r_lost <= 1'b1;
               if (r_drop != {DROP_W{1'b1}}) r_drop <= r_drop + DROP_W'(1);
            end else if (w_push) begin
               r_lost <= 1'b0;
            end
         end
      end
   end

   assign rd_valid   = r_valid;
   assign rd_data    = r_head;
   assign fill_level = r_count;
   assign full       = r_full;
   assign drop_count = r_drop;

endmodule

// File: tb/tb_trace_event_buffer.sv
// Directed bench for trace_event_buffer: stop-on-full, overwrite and short
// timestamp instances share the channel inputs; a queue scoreboard holds expected entries.
module tb_trace_event_buffer;

   logic        clk = 1'b0;
   logic        rst, clear;
   logic        te0, te1, te2;
   logic        rdy0, rdy1, rdy2;
   logic [3:0]  ch_mask;
   logic [39:0] ch_data;

   logic        v0, v1, v2;
   logic [60:0] d0, d1;
   logic [48:0] d2;
   logic [4:0]  lv0, lv1, lv2;
   logic        f0, f1, f2;
   logic [7:0]  dc0, dc1, dc2;

   logic [60:0] q0[$];
   logic [60:0] q1[$];
   logic [48:0] q2[$];

   int          checks = 0;
   int          errors = 0;
   int          tb_ts  = 0;
   int          m_cnt  = 0;
   int          m_drop = 0;
   logic        m_lost = 1'b0;
   bit          m_ow   = 1'b0;
   logic [63:0] last_d = '0;

   always #5 clk = ~clk;

   // Timestamp the DUTs will record at the next rising edge
   always @(posedge clk) tb_ts <= rst ? 0 : tb_ts + 1;

   trace_event_buffer #(.OVERWRITE(0)) u_stop (
      .clk(clk), .rst(rst), .trace_enable(te0), .clear(clear), .ch_mask(ch_mask),
      .ch_data(ch_data), .rd_valid(v0), .rd_ready(rdy0), .rd_data(d0),
      .fill_level(lv0), .full(f0), .drop_count(dc0));

   trace_event_buffer #(.OVERWRITE(1)) u_ovw (
      .clk(clk), .rst(rst), .trace_enable(te1), .clear(clear), .ch_mask(ch_mask),
      .ch_data(ch_data), .rd_valid(v1), .rd_ready(rdy1), .rd_data(d1),
      .fill_level(lv1), .full(f1), .drop_count(dc1));

   trace_event_buffer #(.TS_W(4)) u_ts4 (
      .clk(clk), .rst(rst), .trace_enable(te2), .clear(clear), .ch_mask(ch_mask),
      .ch_data(ch_data), .rd_valid(v2), .rd_ready(rdy2), .rd_data(d2),
      .fill_level(lv2), .full(f2), .drop_count(dc2));

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q0.delete(); q1.delete(); q2.delete();
      m_cnt = 0; m_drop = 0; m_lost = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      model_reset();
   endtask

   task automatic push_exp(input int k);
      case (k)
         0: q0.push_back({m_lost, 16'(tb_ts), 4'b0001, ch_data});
         1: q1.push_back({m_lost, 16'(tb_ts), 4'b0001, ch_data});
         default: q2.push_back({m_lost, 4'(tb_ts), 4'b0001, ch_data});
      endcase
   endtask

   task automatic drop_oldest(input int k);
      case (k)
         0: q0.delete(0);
         1: q1.delete(0);
         default: q2.delete(0);
      endcase
   endtask

   // Change channel 0 for the next edge and update the expected FIFO model
   task automatic drive_event(input int k);
      ch_data[9:0] = ch_data[9:0] + 10'd1;
      if (m_cnt < 16) begin
         push_exp(k); m_cnt++; m_lost = 1'b0;
      end else if (!m_ow) begin
         m_lost = 1'b1; m_drop++;
      end else begin
         drop_oldest(k); push_exp(k); m_lost = 1'b1; m_drop++;
      end
   endtask

   task automatic read_one(input int k);
      case (k)
         0: begin
            chk("rd_valid0", 64'(v0), 64'd1);
            chk("rd_data0", 64'(d0), 64'(q0[0]));
            last_d = 64'(d0); q0.delete(0); rdy0 = 1'b1;
         end
         1: begin
            chk("rd_valid1", 64'(v1), 64'd1);
            chk("rd_data1", 64'(d1), 64'(q1[0]));
            last_d = 64'(d1); q1.delete(0); rdy1 = 1'b1;
         end
         default: begin
            chk("rd_valid2", 64'(v2), 64'd1);
            chk("rd_data2", 64'(d2), 64'(q2[0]));
            last_d = 64'(d2); q2.delete(0); rdy2 = 1'b1;
         end
      endcase
      m_cnt--;
      tick();
      rdy0 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0;
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0;
      te0 = 1'b0; te1 = 1'b0; te2 = 1'b0;
      rdy0 = 1'b0; rdy1 = 1'b0; rdy2 = 1'b0;
      ch_mask = 4'hF;
      ch_data = {10'd3, 10'd2, 10'd1, 10'd0};
      tick(); tick();
      chk("rst_valid", 64'(v0), 64'd0);
      chk("rst_level", 64'(lv0), 64'd0);
      chk("rst_full", 64'(f0), 64'd0);
      chk("rst_drop", 64'(dc0), 64'd0);
      rst = 1'b0;

      // Constant channels: arming and running record nothing
      te0 = 1'b1;
      repeat (50) tick();
      chk("idle_valid", 64'(v0), 64'd0);
      chk("idle_level", 64'(lv0), 64'd0);

      // Fresh reset, then ch0 0->5 at ts 7
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < 20 && tb_ts != 7; i++) tick();
      chk("sync_ts7", 64'(tb_ts), 64'd7);
      ch_data[9:0] = 10'd5;
      tick();
      chk("ev_valid", 64'(v0), 64'd1);
      chk("ev_data", 64'(d0), 64'({1'b0, 16'd7, 4'b0001, ch_data}));
      chk("ev_level", 64'(lv0), 64'd1);
      rdy0 = 1'b1; tick(); rdy0 = 1'b0;
      chk("ev_popped", 64'(v0), 64'd0);

      // Masked channel change is ignored
      ch_mask = 4'b1110;
      ch_data[9:0] = 10'd0;
      tick();
      chk("mask_valid", 64'(v0), 64'd0);
      chk("mask_level", 64'(lv0), 64'd0);
      ch_mask = 4'hF;

      // Stop-on-full: 18 events into 16 entries
      do_clear();
      m_ow = 1'b0;
      repeat (18) begin drive_event(0); tick(); end
      chk("stop_full", 64'(f0), 64'd1);
      chk("stop_level", 64'(lv0), 64'd16);
      chk("stop_drop", 64'(dc0), 64'd2);
      read_one(0);
      drive_event(0); tick();
      chk("stop_refill", 64'(lv0), 64'd16);
      while (q0.size() > 0) read_one(0);
      chk("stop_last_lost", last_d[60], 64'd1);
      chk("stop_drop_kept", 64'(dc0), 64'd2);
      chk("stop_empty", 64'(v0), 64'd0);

      // Full FIFO: push and pop in the same cycle, then clear beats an event
      do_clear();
      repeat (16) begin drive_event(0); tick(); end
      chk("pp_full", 64'(lv0), 64'd16);
      chk("pp_head", 64'(d0), 64'(q0[0]));
      q0.delete(0); m_cnt--;
      drive_event(0);
      rdy0 = 1'b1; tick(); rdy0 = 1'b0;
      chk("pp_level", 64'(lv0), 64'd16);
      chk("pp_drop", 64'(dc0), 64'd0);
      chk("pp_fullflag", 64'(f0), 64'd1);
      clear = 1'b1;
      ch_data[9:0] = ch_data[9:0] + 10'd1;
      tick();
      clear = 1'b0;
      model_reset();
      chk("clr_level", 64'(lv0), 64'd0);
      chk("clr_valid", 64'(v0), 64'd0);
      chk("clr_drop", 64'(dc0), 64'd0);

      // Overwrite mode: 20 events at ts 100..119
      te0 = 1'b0;
      rst = 1'b1; tick(); rst = 1'b0;
      te1 = 1'b1;
      model_reset();
      m_ow = 1'b1;
      for (int i = 0; i < 200 && tb_ts != 100; i++) tick();
      chk("sync_ts100", 64'(tb_ts), 64'd100);
      repeat (20) begin drive_event(1); tick(); end
      chk("ovw_level", 64'(lv1), 64'd16);
      chk("ovw_full", 64'(f1), 64'd1);
      chk("ovw_drop", 64'(dc1), 64'd4);
      chk("ovw_first_ts", 64'(d1[59:44]), 64'd104);
      chk("ovw_first_lost", 64'(d1[60]), 64'd0);
      while (q1.size() > 0) read_one(1);
      chk("ovw_last_ts", last_d[59:44], 64'd119);
      chk("ovw_last_lost", last_d[60], 64'd1);

      // 4-bit timestamp wrap, disable keeps contents, re-enable re-arms cleanly
      te1 = 1'b0;
      te2 = 1'b1;
      do_clear();
      m_ow = 1'b0;
      repeat (3) tick();
      for (int i = 0; i < 40 && (tb_ts % 16) != 14; i++) tick();
      drive_event(2); tick();
      chk("ts4_valid", 64'(v2), 64'd1);
      chk("ts4_first", 64'(d2[47:44]), 64'd14);
      for (int i = 0; i < 40 && (tb_ts % 16) != 1; i++) tick();
      drive_event(2); tick();
      te2 = 1'b0;
      tick(); tick();
      chk("ts4_level", 64'(lv2), 64'd2);
      chk("ts4_full", 64'(f2), 64'd0);
      while (q2.size() > 0) read_one(2);
      chk("ts4_last", last_d[47:44], 64'd1);
      ch_data[19:10] = ch_data[19:10] + 10'd7;
      te2 = 1'b1;
      repeat (6) tick();
      chk("rearm_valid", 64'(v2), 64'd0);
      chk("rearm_level", 64'(lv2), 64'd0);
      chk("rearm_drop", 64'(dc2), 64'd0);

      // Reset alongside an event abandons the push
      ch_data[9:0] = ch_data[9:0] + 10'd1;
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rstmid_valid", 64'(v2), 64'd0);
      chk("rstmid_level", 64'(lv2), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
